img_rsz_src_arb: RTL and testbench
==================================

// Module: img_rsz_src_arb
// PURPOSE
//  Frame-granular round-robin arbiter that shares the single image resizer between NUM_SRC pixel sources.
//  Sits in front of the resizer's image capturer and locks one source for a whole image.
//  Switches only after the resizer reports the resized image fully forwarded (RszImgComp).
//  The selected stream is a zero-latency mux; arbitration and frame tracking are sequential.
// PARAMETERS
//  NUM_SRC           4   number of requesting pixel sources (>=2)
//  PXL_W             24  flattened pixel payload width (all primary colours)
//  IMG_WIDTH_IDX_W   11  width of X index / image width fields
//  IMG_HEIGHT_IDX_W  11  width of Y index / image height fields
//  SRC_ID_W          $clog2(NUM_SRC)  grant index width (derived)
// PORTS
//  Clk            in   1                            clock
//  Reset          in   1                            synchronous, active-high reset
//  SrcPxlData     in   NUM_SRC*PXL_W                per-source pixel payload, source i at [i*PXL_W+:PXL_W]
//  SrcPxlX        in   NUM_SRC*IMG_WIDTH_IDX_W      per-source pixel X index
//  SrcPxlY        in   NUM_SRC*IMG_HEIGHT_IDX_W     per-source pixel Y index
//  SrcImgWidth    in   NUM_SRC*IMG_WIDTH_IDX_W      per-source image width in pixels (>=1)
//  SrcImgHeight   in   NUM_SRC*IMG_HEIGHT_IDX_W     per-source image height in pixels (>=1)
//  SrcPxlVld      in   NUM_SRC                      per-source pixel valid
//  SrcPxlRdy      out  NUM_SRC                      per-source pixel ready
//  PxlData        out  PXL_W                        muxed payload to capturer
//  PxlX / PxlY    out  IMG_WIDTH_IDX_W / IMG_HEIGHT_IDX_W  muxed pixel indices
//  ImgWidth       out  IMG_WIDTH_IDX_W              latched width of granted frame
//  ImgHeight      out  IMG_HEIGHT_IDX_W             latched height of granted frame
//  PxlVld         out  1                            muxed valid to capturer
//  PxlRdy         in   1                            capturer ready
//  RszImgComp     in   1                            resizer finished forwarding current image (1-cycle pulse)
//  GntVld         out  1                            a source currently owns the resizer
//  GntId          out  SRC_ID_W                     owning source index
//  FrmDone        out  1                            1-cycle pulse when a frame's last pixel is accepted downstream
// BEHAVIOUR
//  - One clock, Clk; Reset synchronous active-high, priority over all other events, legal mid-frame.
//  - Reset values: state=IDLE, RrPtr=0, GntVld=0, GntId=0, ImgWidth/ImgHeight='1, counters 0,
//    SrcPxlRdy=0, PxlVld=0, FrmDone=0.
//  - FSM IDLE -> XFER -> WAIT_CMP -> IDLE.
//  - IDLE: source i eligible iff SrcPxlVld[i] & SrcPxlX[i]==0 & SrcPxlY[i]==0 (frame start).
//    Winner = first eligible at or after RrPtr (wrap modulo NUM_SRC). If any eligible: register GntId=winner,
//    ImgWidth/ImgHeight = winner's SrcImgWidth/SrcImgHeight, counters=0, go XFER next cycle.
//    All SrcPxlRdy=0, PxlVld=0 in IDLE (one-cycle arbitration bubble).
//  - Ineligible valid sources (mid-frame pixels, losers) are stalled (Rdy=0); never dropped.
//  - XFER: combinational mux of GntId source onto PxlData/PxlX/PxlY/PxlVld;
//    SrcPxlRdy[GntId]=PxlRdy, all others 0. Handshake = PxlVld & PxlRdy.
//  - Per handshake: CntHor++; if CntHor==ImgWidth-1 then CntHor=0, CntVer++.
//    Last pixel = CntHor==ImgWidth-1 & CntVer==ImgHeight-1; compare in full field width, no overflow.
//  - Last-pixel handshake: FrmDone=1 that cycle; next state WAIT_CMP.
//  - WAIT_CMP: all SrcPxlRdy=0, PxlVld=0; GntVld/GntId held. On RszImgComp: RrPtr=GntId+1 (wrap at NUM_SRC-1 -> 0),
//    GntVld=0, go IDLE.
//  - Simultaneous last-pixel handshake and RszImgComp in XFER: go directly IDLE, RrPtr updated, FrmDone=1.
//  - RszImgComp in IDLE or in XFER before the last pixel: ignored.
//  - ImgWidth/ImgHeight stable for the whole grant; changes on source fields mid-frame are ignored.
//  - GntVld=1 exactly in XFER and WAIT_CMP. Throughput in XFER: 1 pixel/cycle when PxlRdy=1.
//  - 1x1 image: first handshake is also last -> FrmDone, WAIT_CMP.
// TESTING
//  - Single src0 4x2 frame, PxlRdy=1: GntId=0 one cycle after Vld; 8 back-to-back handshakes; FrmDone on 8th;
//    Rdy low until RszImgComp.
//  - src1 and src3 both at (0,0), RrPtr=0: src1 granted. After comp, src3 granted; after comp, RrPtr=0.
//  - src2 presents X=5 mid-frame while IDLE: SrcPxlRdy[2]=0 indefinitely, no grant; switches to (0,0) -> granted.
//  - Random PxlRdy backpressure on 3x3 frame: exactly 9 handshakes, data/X/Y order preserved, loser src held.
//  - RszImgComp coincident with last handshake: IDLE next cycle, no WAIT_CMP; early RszImgComp mid-XFER ignored.
//  - Reset asserted at pixel 5 of 4x4 frame: next cycle GntVld=0, all Rdy=0, RrPtr=0; new frame grants cleanly.

Source files
------------

// File: rtl/img_rsz_src_arb.sv
// Frame-granular round-robin arbiter in front of the image resizer's capturer.
// One source owns the resizer from its frame-start pixel until the resizer reports the image forwarded.
module img_rsz_src_arb #(
    parameter int NUM_SRC          = 4,
    parameter int PXL_W            = 24,
    parameter int IMG_WIDTH_IDX_W  = 11,
    parameter int IMG_HEIGHT_IDX_W = 11,
    parameter int SRC_ID_W         = $clog2(NUM_SRC)
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic [NUM_SRC*PXL_W-1:0]             SrcPxlData,
    input  logic [NUM_SRC*IMG_WIDTH_IDX_W-1:0]   SrcPxlX,
    input  logic [NUM_SRC*IMG_HEIGHT_IDX_W-1:0]  SrcPxlY,
    input  logic [NUM_SRC*IMG_WIDTH_IDX_W-1:0]   SrcImgWidth,
    input  logic [NUM_SRC*IMG_HEIGHT_IDX_W-1:0]  SrcImgHeight,
    input  logic [NUM_SRC-1:0]                   SrcPxlVld,
    output logic [NUM_SRC-1:0]                   SrcPxlRdy,
    output logic [PXL_W-1:0]                     PxlData,
    output logic [IMG_WIDTH_IDX_W-1:0]           PxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0]          PxlY,
    output logic [IMG_WIDTH_IDX_W-1:0]           ImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0]          ImgHeight,
    output logic                                 PxlVld,
    input  logic                                 PxlRdy,
    input  logic                                 RszImgComp,
    output logic                                 GntVld,
    output logic [SRC_ID_W-1:0]                  GntId,
    output logic                                 FrmDone,
    output logic [1:0]                           DbgState,
    output logic [SRC_ID_W-1:0]                  DbgRrPtr
);

    // Handshakes (source side and capturer side): a transfer happens in a cycle where
    // valid and ready are both high; valid never waits on ready, and a stalled source
    // must hold its pixel until it is accepted.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_CMP = 2'd2
    } state_t;

    state_t                      state_q,      state_d;
    logic [SRC_ID_W-1:0]         rr_ptr_q,     rr_ptr_d;
    logic [SRC_ID_W-1:0]         gnt_id_q,     gnt_id_d;
    logic [IMG_WIDTH_IDX_W-1:0]  img_width_q,  img_width_d;
    logic [IMG_HEIGHT_IDX_W-1:0] img_height_q, img_height_d;
    logic [IMG_WIDTH_IDX_W-1:0]  cnt_hor_q,    cnt_hor_d;
    logic [IMG_HEIGHT_IDX_W-1:0] cnt_ver_q,    cnt_ver_d;

    logic [NUM_SRC-1:0]  elig;
    logic                win_found;
    logic [SRC_ID_W-1:0] win_id;
    logic [SRC_ID_W-1:0] rr_next;
    logic                hs;
    logic                hor_end;
    logic                last_pxl;
    int                  idx;

    // A source may only win at its frame start, so a grant always begins on pixel (0,0).
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = SrcPxlVld[i]
                    && (SrcPxlX[i*IMG_WIDTH_IDX_W +: IMG_WIDTH_IDX_W] == '0)
                    && (SrcPxlY[i*IMG_HEIGHT_IDX_W +: IMG_HEIGHT_IDX_W] == '0);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_id    = SRC_ID_W'(idx);
            end
        end
    end

    always_comb begin
        PxlData = SrcPxlData[int'(gnt_id_q)*PXL_W +: PXL_W];
        PxlX    = SrcPxlX[int'(gnt_id_q)*IMG_WIDTH_IDX_W +: IMG_WIDTH_IDX_W];
        PxlY    = SrcPxlY[int'(gnt_id_q)*IMG_HEIGHT_IDX_W +: IMG_HEIGHT_IDX_W];
    end

    assign rr_next  = (gnt_id_q == SRC_ID_W'(NUM_SRC - 1)) ? '0 : gnt_id_q + SRC_ID_W'(1);
    assign hor_end  = (cnt_hor_q == img_width_q - IMG_WIDTH_IDX_W'(1));
    assign last_pxl = hor_end && (cnt_ver_q == img_height_q - IMG_HEIGHT_IDX_W'(1));
    assign hs       = PxlVld && PxlRdy;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        img_width_d  = img_width_q;
        img_height_d = img_height_q;
        cnt_hor_d    = cnt_hor_q;
        cnt_ver_d    = cnt_ver_q;
        SrcPxlRdy    = '0;
        PxlVld       = 1'b0;
        FrmDone      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_id_d     = win_id;
                    img_width_d  = SrcImgWidth[int'(win_id)*IMG_WIDTH_IDX_W +: IMG_WIDTH_IDX_W];
                    img_height_d = SrcImgHeight[int'(win_id)*IMG_HEIGHT_IDX_W +: IMG_HEIGHT_IDX_W];
                    cnt_hor_d    = '0;
                    cnt_ver_d    = '0;
                    state_d      = XFER;
                end
            end
            XFER: begin
                PxlVld              = SrcPxlVld[gnt_id_q];
                SrcPxlRdy[gnt_id_q] = PxlRdy;
                if (hs) begin
                    if (last_pxl) begin
                        FrmDone   = 1'b1;
                        cnt_hor_d = '0;
                        cnt_ver_d = '0;
                        // The resizer may finish on the very cycle the last pixel goes in.
                        if (RszImgComp) begin
                            rr_ptr_d = rr_next;
                            state_d  = IDLE;
                        end else begin
                            state_d  = WAIT_CMP;
                        end
                    end else if (hor_end) begin
                        cnt_hor_d = '0;
                        cnt_ver_d = cnt_ver_q + IMG_HEIGHT_IDX_W'(1);
                    end else begin
                        cnt_hor_d = cnt_hor_q + IMG_WIDTH_IDX_W'(1);
                    end
                end
            end
            WAIT_CMP: begin
                if (RszImgComp) begin
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_id_q     <= '0;
            img_width_q  <= '1;
            img_height_q <= '1;
            cnt_hor_q    <= '0;
            cnt_ver_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            img_width_q  <= img_width_d;
            img_height_q <= img_height_d;
            cnt_hor_q    <= cnt_hor_d;
            cnt_ver_q    <= cnt_ver_d;
        end
    end

    assign GntVld    = (state_q == XFER) || (state_q == WAIT_CMP);
    assign GntId     = gnt_id_q;
    assign ImgWidth  = img_width_q;
    assign ImgHeight = img_height_q;
    assign DbgState  = state_q;
    assign DbgRrPtr  = rr_ptr_q;

endmodule

// File: tb/tb_img_rsz_src_arb.sv
// Directed bench for img_rsz_src_arb: frame locking, round-robin order, stalls,
// backpressure, completion corner cases and mid-frame reset.
module tb_img_rsz_src_arb;

    localparam int NS = 4;
    localparam int PW = 24;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int IW = 2;

    logic               clk;
    logic               Reset;
    logic [NS*PW-1:0]   SrcPxlData;
    logic [NS*XW-1:0]   SrcPxlX;
    logic [NS*YW-1:0]   SrcPxlY;
    logic [NS*XW-1:0]   SrcImgWidth;
    logic [NS*YW-1:0]   SrcImgHeight;
    logic [NS-1:0]      SrcPxlVld;
    logic [NS-1:0]      SrcPxlRdy;
    logic [PW-1:0]      PxlData;
    logic [XW-1:0]      PxlX;
    logic [YW-1:0]      PxlY;
    logic [XW-1:0]      ImgWidth;
    logic [YW-1:0]      ImgHeight;
    logic               PxlVld;
    logic               PxlRdy;
    logic               RszImgComp;
    logic               GntVld;
    logic [IW-1:0]      GntId;
    logic               FrmDone;
    logic [1:0]         DbgState;
    logic [IW-1:0]      DbgRrPtr;

    logic [PW-1:0] s_data[NS];
    logic [XW-1:0] s_x[NS];
    logic [YW-1:0] s_y[NS];
    logic [XW-1:0] s_w[NS];
    logic [YW-1:0] s_h[NS];
    logic [NS-1:0] s_vld;

    int checks   = 0;
    int failures = 0;
    int hs_cnt;
    int k;
    bit pat[20] = '{1,0,1,1,0,0,1,0,1,1,1,0,1,1,0,1,1,1,1,1};

    img_rsz_src_arb dut (
        .Clk(clk), .Reset(Reset),
        .SrcPxlData(SrcPxlData), .SrcPxlX(SrcPxlX), .SrcPxlY(SrcPxlY),
        .SrcImgWidth(SrcImgWidth), .SrcImgHeight(SrcImgHeight),
        .SrcPxlVld(SrcPxlVld), .SrcPxlRdy(SrcPxlRdy),
        .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY),
        .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
        .PxlVld(PxlVld), .PxlRdy(PxlRdy), .RszImgComp(RszImgComp),
        .GntVld(GntVld), .GntId(GntId), .FrmDone(FrmDone),
        .DbgState(DbgState), .DbgRrPtr(DbgRrPtr)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        SrcPxlData = '0; SrcPxlX = '0; SrcPxlY = '0; SrcImgWidth = '0; SrcImgHeight = '0;
        for (int i = 0; i < NS; i++) begin
            SrcPxlData[i*PW +: PW]   = s_data[i];
            SrcPxlX[i*XW +: XW]      = s_x[i];
            SrcPxlY[i*YW +: YW]      = s_y[i];
            SrcImgWidth[i*XW +: XW]  = s_w[i];
            SrcImgHeight[i*YW +: YW] = s_h[i];
        end
        SrcPxlVld = s_vld;
    end

    function automatic logic [PW-1:0] pix_val(input int s, input int x, input int y);
        return {8'(s), 8'(y), 8'(x)};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int s, input int x, input int y, input int w, input int h);
        s_x[s]    = XW'(x);
        s_y[s]    = YW'(y);
        s_w[s]    = XW'(w);
        s_h[s]    = YW'(h);
        s_data[s] = pix_val(s, x, y);
        s_vld[s]  = 1'b1;
    endtask

    task automatic comp_pulse();
        RszImgComp = 1'b1;
        tick();
        RszImgComp = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; PxlRdy = 1'b1; RszImgComp = 1'b0; s_vld = '0;
        for (int i = 0; i < NS; i++) begin
            s_data[i] = '0; s_x[i] = '0; s_y[i] = '0; s_w[i] = XW'(1); s_h[i] = YW'(1);
        end
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        chk("rst_gntvld", 32'(GntVld), 0);
        chk("rst_gntid", 32'(GntId), 0);
        chk("rst_width", 32'(ImgWidth), 32'h7ff);
        chk("rst_height", 32'(ImgHeight), 32'h7ff);
        chk("rst_rdy", 32'(SrcPxlRdy), 0);
        chk("rst_vld", 32'(PxlVld), 0);
        chk("rst_frmdone", 32'(FrmDone), 0);
        chk("rst_state", 32'(DbgState), 0);
        chk("rst_rrptr", 32'(DbgRrPtr), 0);

        // src0 4x2 frame, back-to-back
        set_pix(0, 0, 0, 4, 2);
        #1;
        chk("t1_bubble_gnt", 32'(GntVld), 0);
        chk("t1_bubble_rdy", 32'(SrcPxlRdy), 0);
        tick();
        chk("t1_gntvld", 32'(GntVld), 1);
        chk("t1_gntid", 32'(GntId), 0);
        chk("t1_width", 32'(ImgWidth), 4);
        chk("t1_height", 32'(ImgHeight), 2);
        for (int p = 0; p < 8; p++) begin
            set_pix(0, p % 4, p / 4, 4, 2);
            #1;
            chk("t1_vld", 32'(PxlVld), 1);
            chk("t1_rdy", 32'(SrcPxlRdy), 32'h1);
            chk("t1_x", 32'(PxlX), 32'(p % 4));
            chk("t1_y", 32'(PxlY), 32'(p / 4));
            chk("t1_data", 32'(PxlData), 32'(pix_val(0, p % 4, p / 4)));
            chk("t1_frmdone", 32'(FrmDone), (p == 7) ? 1 : 0);
            tick();
        end
        set_pix(0, 0, 0, 4, 2);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t1_wait_rdy", 32'(SrcPxlRdy), 0);
            chk("t1_wait_vld", 32'(PxlVld), 0);
            chk("t1_wait_gnt", 32'(GntVld), 1);
            chk("t1_wait_state", 32'(DbgState), 2);
            tick();
        end
        comp_pulse();
        s_vld[0] = 1'b0;
        #1;
        chk("t1_done_gnt", 32'(GntVld), 0);
        chk("t1_done_state", 32'(DbgState), 0);
        chk("t1_done_rr", 32'(DbgRrPtr), 1);

        // src1 and src3 at frame start, 1x1 images, round robin with wrap
        set_pix(1, 0, 0, 1, 1);
        set_pix(3, 0, 0, 1, 1);
        #1;
        chk("t2_bubble", 32'(GntVld), 0);
        tick();
        chk("t2_a_gntid", 32'(GntId), 1);
        chk("t2_a_rdy", 32'(SrcPxlRdy), 32'h2);
        chk("t2_a_data", 32'(PxlData), 32'(pix_val(1, 0, 0)));
        chk("t2_a_frmdone", 32'(FrmDone), 1);
        chk("t2_a_width", 32'(ImgWidth), 1);
        tick();
        s_vld[1] = 1'b0;
        #1;
        chk("t2_a_wait", 32'(DbgState), 2);
        chk("t2_a_wait_rdy", 32'(SrcPxlRdy), 0);
        comp_pulse();
        #1;
        chk("t2_a_rr", 32'(DbgRrPtr), 2);
        chk("t2_a_idle", 32'(GntVld), 0);
        tick();
        chk("t2_b_gntid", 32'(GntId), 3);
        chk("t2_b_rdy", 32'(SrcPxlRdy), 32'h8);
        chk("t2_b_frmdone", 32'(FrmDone), 1);
        tick();
        s_vld[3] = 1'b0;
        comp_pulse();
        #1;
        chk("t2_b_rr_wrap", 32'(DbgRrPtr), 0);

        // src2 mid-frame while idle is stalled; comp in idle ignored
        set_pix(2, 5, 0, 2, 1);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t3_stall_rdy", 32'(SrcPxlRdy), 0);
            chk("t3_stall_gnt", 32'(GntVld), 0);
            RszImgComp = (c == 1);
            tick();
            RszImgComp = 1'b0;
        end
        #1;
        chk("t3_idle_comp_rr", 32'(DbgRrPtr), 0);
        set_pix(2, 0, 0, 2, 1);
        tick();
        chk("t3_gntid", 32'(GntId), 2);
        chk("t3_gntvld", 32'(GntVld), 1);
        RszImgComp = 1'b1;
        #1;
        chk("t3_p0_frmdone", 32'(FrmDone), 0);
        tick();
        RszImgComp = 1'b0;
        set_pix(2, 1, 0, 2, 1);
        #1;
        chk("t3_early_comp_ignored", 32'(DbgState), 1);
        chk("t3_p1_x", 32'(PxlX), 1);
        chk("t3_p1_frmdone", 32'(FrmDone), 1);
        RszImgComp = 1'b1;
        tick();
        RszImgComp = 1'b0;
        s_vld[2] = 1'b0;
        #1;
        chk("t4_coinc_state", 32'(DbgState), 0);
        chk("t4_coinc_rr", 32'(DbgRrPtr), 3);
        chk("t4_coinc_gnt", 32'(GntVld), 0);

        // 3x3 frame under backpressure, src1 loses and is held
        set_pix(0, 0, 0, 3, 3);
        set_pix(1, 0, 0, 4, 4);
        tick();
        chk("t5_gntid", 32'(GntId), 0);
        chk("t5_width", 32'(ImgWidth), 3);
        k = 0;
        hs_cnt = 0;
        for (int c = 0; c < 20 && k < 9; c++) begin
            PxlRdy = pat[c];
            set_pix(0, k % 3, k / 3, 3, 3);
            if (k >= 4) s_w[0] = XW'(9);
            #1;
            chk("t5_x", 32'(PxlX), 32'(k % 3));
            chk("t5_y", 32'(PxlY), 32'(k / 3));
            chk("t5_data", 32'(PxlData), 32'(pix_val(0, k % 3, k / 3)));
            chk("t5_rdy", 32'(SrcPxlRdy), pat[c] ? 32'h1 : 32'h0);
            chk("t5_frmdone", 32'(FrmDone), (pat[c] && k == 8) ? 1 : 0);
            chk("t5_width_stable", 32'(ImgWidth), 3);
            if (PxlVld && PxlRdy) hs_cnt++;
            tick();
            if (pat[c]) k++;
        end
        PxlRdy = 1'b1;
        #1;
        chk("t5_hs_count", 32'(hs_cnt), 9);
        chk("t5_wait_state", 32'(DbgState), 2);
        chk("t5_loser_held", 32'(SrcPxlRdy), 0);
        comp_pulse();
        s_vld[0] = 1'b0;
        #1;
        chk("t5_rr", 32'(DbgRrPtr), 1);
        tick();
        chk("t5_loser_gnt", 32'(GntId), 1);
        chk("t5_loser_width", 32'(ImgWidth), 4);

        // reset at pixel 5 of src1's 4x4 frame
        for (int p = 0; p < 5; p++) begin
            set_pix(1, p % 4, p / 4, 4, 4);
            #1;
            chk("t6_x", 32'(PxlX), 32'(p % 4));
            chk("t6_frmdone", 32'(FrmDone), 0);
            tick();
        end
        set_pix(1, 1, 1, 4, 4);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(GntVld), 0);
        chk("t6_rst_rdy", 32'(SrcPxlRdy), 0);
        chk("t6_rst_rr", 32'(DbgRrPtr), 0);
        chk("t6_rst_state", 32'(DbgState), 0);
        chk("t6_rst_width", 32'(ImgWidth), 32'h7ff);
        tick();
        chk("t6_midframe_no_gnt", 32'(GntVld), 0);
        set_pix(1, 0, 0, 1, 1);
        set_pix(2, 0, 0, 1, 1);
        tick();
        chk("t6_regnt_id", 32'(GntId), 1);
        chk("t6_regnt_frmdone", 32'(FrmDone), 1);
        chk("t6_regnt_width", 32'(ImgWidth), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
